// File: rtl/alrdwr_pkg.sv
// rtl/alrdwr_pkg.sv - shared helpers for the AL read/write N-to-1 mux and its arbiters.
// Honours ALRDWR_MUX_ID_TAG_EN when sizing the target-side ID.
package alrdwr_pkg;

`ifdef ALRDWR_MUX_ID_TAG_EN
  localparam bit ID_TAG_EN = 1'b1;
`else
  localparam bit ID_TAG_EN = 1'b0;
`endif

  function automatic int m_id_width(input int id_w, input int sc_bits);
    return id_w + (ID_TAG_EN ? sc_bits : 0);
  endfunction

  function automatic int rr_next(input int idx, input int count);
    return (idx >= count - 1) ? 0 : idx + 1;
  endfunction

  // First set request at or after ptr, wrapping; returns ptr when nothing is requested.
  function automatic int rr_first(input logic [31:0] req, input int ptr, input int count);
    int idx;
    rr_first = ptr;
    for (int k = count - 1; k >= 0; k--) begin
      idx = ptr + k;
      if (idx >= count) idx = idx - count;
      if (req[idx]) rr_first = idx;
    end
  endfunction

endpackage

// File: rtl/al_rr_arbiter.sv
// rtl/al_rr_arbiter.sv - round-robin arbiter with combinational grant and stall lock.
module al_rr_arbiter
  import alrdwr_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          ready,
  output logic [IW-1:0] gnt,
  output logic          gnt_valid,
  output logic          hs
);

  logic [IW-1:0] ptr_q, ptr_d, lock_idx_q, lock_idx_d;
  logic          lock_q, lock_d;

  always_comb begin
    if (lock_q) begin
      gnt       = lock_idx_q;
      gnt_valid = req[lock_idx_q];
    end else begin
      gnt       = IW'(rr_first(32'(req), int'(ptr_q), N));
      gnt_valid = |req;
    end
    hs = gnt_valid & ready;

    ptr_d      = ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    // A stalled grant is pinned so a newly raised valid cannot change the payload.
    if (hs) begin
      ptr_d  = IW'(rr_next(int'(gnt), N));
      lock_d = 1'b0;
    end else begin
      lock_d     = gnt_valid;
      lock_idx_d = gnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: rtl/alrdwr_mux_arb.sv
// rtl/alrdwr_mux_arb.sv - N-to-1 AL initiator mux with round-robin W/AR arbitration and R routing.
// ALRDWR_MUX_ID_TAG_EN: tag AR IDs with the port index and route R by ID instead of an in-order FIFO.
module alrdwr_mux_arb
  import alrdwr_pkg::*;
#(
  parameter int DATA_BITS        = 2,
  parameter int DATA_WIDTH       = 8 << DATA_BITS,
  parameter int ADDR_WIDTH       = 16,
  parameter int ID_WIDTH         = 1,
  parameter int SLAVE_COUNT      = 2,
  parameter int SLAVE_COUNT_BITS = $clog2(SLAVE_COUNT),
  parameter int RD_OUTSTANDING   = 4,
  parameter int M_ID_WIDTH       = m_id_width(ID_WIDTH, SLAVE_COUNT_BITS)
)(
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic [SLAVE_COUNT*(ADDR_WIDTH-DATA_BITS)-1:0]  sn_al_waddr,
  input  logic [SLAVE_COUNT*DATA_WIDTH-1:0]              sn_al_wdata,
  input  logic [SLAVE_COUNT-1:0]                         sn_al_wvalid,
  input  logic [SLAVE_COUNT*ID_WIDTH-1:0]                sn_al_wid,
  output logic [SLAVE_COUNT-1:0]                         sn_al_wready,
  input  logic [SLAVE_COUNT*(ADDR_WIDTH-DATA_BITS)-1:0]  sn_al_araddr,
  input  logic [SLAVE_COUNT-1:0]                         sn_al_arvalid,
  input  logic [SLAVE_COUNT*ID_WIDTH-1:0]                sn_al_arid,
  output logic [SLAVE_COUNT-1:0]                         sn_al_arready,
  output logic [SLAVE_COUNT*DATA_WIDTH-1:0]              sn_al_rdata,
  output logic [SLAVE_COUNT-1:0]                         sn_al_rvalid,
  output logic [SLAVE_COUNT*ID_WIDTH-1:0]                sn_al_rid,
  input  logic [SLAVE_COUNT-1:0]                         sn_al_rready,
  output logic [ADDR_WIDTH-DATA_BITS-1:0]                m_al_waddr,
  output logic [DATA_WIDTH-1:0]                          m_al_wdata,
  output logic                                           m_al_wvalid,
  output logic [ID_WIDTH-1:0]                            m_al_wid,
  input  logic                                           m_al_wready,
  output logic [ADDR_WIDTH-DATA_BITS-1:0]                m_al_araddr,
  output logic                                           m_al_arvalid,
  output logic [M_ID_WIDTH-1:0]                          m_al_arid,
  input  logic                                           m_al_arready,
  input  logic [DATA_WIDTH-1:0]                          m_al_rdata,
  input  logic                                           m_al_rvalid,
  input  logic [M_ID_WIDTH-1:0]                          m_al_rid,
  output logic                                           m_al_rready,
  output logic                                           rd_err
);

  localparam int AW = ADDR_WIDTH - DATA_BITS;
  localparam int N  = SLAVE_COUNT;
  localparam int IW = SLAVE_COUNT_BITS;
  localparam int CW = $clog2(RD_OUTSTANDING) + 1;

  logic [IW-1:0] w_gnt, ar_gnt;
  logic          w_val, w_hs, ar_val, ar_hs;
  logic [N-1:0]  ar_ok;
  logic          r_err;
  logic          rd_err_q, rd_err_d;

  // Gating requests with rst_n keeps every valid/ready low while reset is asserted.
  al_rr_arbiter #(.N(N), .IW(IW)) u_w_arb (
    .clk(clk), .rst_n(rst_n), .req(sn_al_wvalid & {N{rst_n}}), .ready(m_al_wready),
    .gnt(w_gnt), .gnt_valid(w_val), .hs(w_hs)
  );

  al_rr_arbiter #(.N(N), .IW(IW)) u_ar_arb (
    .clk(clk), .rst_n(rst_n), .req(sn_al_arvalid & ar_ok & {N{rst_n}}), .ready(m_al_arready),
    .gnt(ar_gnt), .gnt_valid(ar_val), .hs(ar_hs)
  );

  assign m_al_wvalid   = w_val;
  assign m_al_waddr    = sn_al_waddr[w_gnt*AW +: AW];
  assign m_al_wdata    = sn_al_wdata[w_gnt*DATA_WIDTH +: DATA_WIDTH];
  assign m_al_wid      = sn_al_wid[w_gnt*ID_WIDTH +: ID_WIDTH];
  assign sn_al_wready  = w_hs ? (N'(1) << w_gnt) : '0;
  assign m_al_arvalid  = ar_val;
  assign m_al_araddr   = sn_al_araddr[ar_gnt*AW +: AW];
  assign sn_al_arready = ar_hs ? (N'(1) << ar_gnt) : '0;
  assign sn_al_rdata   = {N{m_al_rdata}};
  assign sn_al_rid     = {N{m_al_rid[ID_WIDTH-1:0]}};

`ifdef ALRDWR_MUX_ID_TAG_EN
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];
  logic [IW-1:0] r_idx;
  logic          r_ok, r_hs;

  assign m_al_arid = {ar_gnt, sn_al_arid[ar_gnt*ID_WIDTH +: ID_WIDTH]};
  assign r_idx     = m_al_rid[M_ID_WIDTH-1 -: IW];
  assign r_ok      = int'(r_idx) < N;
  assign r_hs      = m_al_rvalid & m_al_rready & r_ok;

  always_comb begin
    sn_al_rvalid = '0;
    m_al_rready  = 1'b0;
    r_err        = 1'b0;
    if (rst_n && m_al_rvalid) begin
      if (!r_ok) begin
        m_al_rready = 1'b1;
        r_err       = 1'b1;
      end else begin
        sn_al_rvalid[r_idx] = 1'b1;
        m_al_rready         = sn_al_rready[r_idx];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      ar_ok[i] = cnt_q[i] != CW'(RD_OUTSTANDING);
      cnt_d[i] = cnt_q[i] + CW'(ar_hs && (ar_gnt == IW'(i)))
                          - CW'(r_hs && (r_idx == IW'(i)) && (cnt_q[i] != '0));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`else
  localparam int PW = $clog2(RD_OUTSTANDING);

  logic [IW-1:0] tag_q [RD_OUTSTANDING];
  logic [IW-1:0] tag_d [RD_OUTSTANDING];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          empty, full, pop;

  assign empty     = cnt_q == '0;
  assign full      = cnt_q == CW'(RD_OUTSTANDING);
  assign ar_ok     = {N{~full}};
  assign m_al_arid = sn_al_arid[ar_gnt*ID_WIDTH +: ID_WIDTH];
  assign pop       = m_al_rvalid & m_al_rready & ~empty;

  // Data arriving with no outstanding tag is drained and flagged rather than stalling the target.
  always_comb begin
    sn_al_rvalid = '0;
    m_al_rready  = 1'b0;
    r_err        = 1'b0;
    if (rst_n && m_al_rvalid) begin
      if (empty) begin
        m_al_rready = 1'b1;
        r_err       = 1'b1;
      end else begin
        sn_al_rvalid[tag_q[rd_q]] = 1'b1;
        m_al_rready               = sn_al_rready[tag_q[rd_q]];
      end
    end
  end

  always_comb begin
    tag_d = tag_q;
    if (ar_hs) tag_d[wr_q] = ar_gnt;
    wr_d  = wr_q + PW'(ar_hs);
    rd_d  = rd_q + PW'(pop);
    cnt_d = cnt_q + CW'(ar_hs) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_OUTSTANDING; i++) tag_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      tag_q <= tag_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
`endif

  assign rd_err_d = rd_err_q | r_err;
  assign rd_err   = rd_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_err_q <= 1'b0;
    else        rd_err_q <= rd_err_d;
  end

endmodule

// File: tb/tb_alrdwr_mux_arb.sv
// tb/tb_alrdwr_mux_arb.sv - randomized self-checking bench for alrdwr_mux_arb against a queue-based model.
module tb_alrdwr_mux_arb;

  localparam int N   = 2;
  localparam int AW  = 14;
  localparam int DW  = 32;
  localparam int IW  = 1;
  localparam int RDO = 4;
  localparam int MIW = alrdwr_pkg::m_id_width(IW, 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N*AW-1:0]   sn_al_waddr, sn_al_araddr;
  logic [N*DW-1:0]   sn_al_wdata, sn_al_rdata;
  logic [N-1:0]      sn_al_wvalid, sn_al_wready, sn_al_arvalid, sn_al_arready;
  logic [N-1:0]      sn_al_rvalid, sn_al_rready;
  logic [N*IW-1:0]   sn_al_wid, sn_al_arid, sn_al_rid;
  logic [AW-1:0]     m_al_waddr, m_al_araddr;
  logic [DW-1:0]     m_al_wdata, m_al_rdata;
  logic              m_al_wvalid, m_al_wready, m_al_arvalid, m_al_arready;
  logic              m_al_rvalid, m_al_rready, rd_err;
  logic [IW-1:0]     m_al_wid;
  logic [MIW-1:0]    m_al_arid, m_al_rid;

  always #5 clk = ~clk;

  alrdwr_mux_arb dut (
    .clk(clk), .rst_n(rst_n),
    .sn_al_waddr(sn_al_waddr), .sn_al_wdata(sn_al_wdata), .sn_al_wvalid(sn_al_wvalid),
    .sn_al_wid(sn_al_wid), .sn_al_wready(sn_al_wready),
    .sn_al_araddr(sn_al_araddr), .sn_al_arvalid(sn_al_arvalid), .sn_al_arid(sn_al_arid),
    .sn_al_arready(sn_al_arready),
    .sn_al_rdata(sn_al_rdata), .sn_al_rvalid(sn_al_rvalid), .sn_al_rid(sn_al_rid),
    .sn_al_rready(sn_al_rready),
    .m_al_waddr(m_al_waddr), .m_al_wdata(m_al_wdata), .m_al_wvalid(m_al_wvalid),
    .m_al_wid(m_al_wid), .m_al_wready(m_al_wready),
    .m_al_araddr(m_al_araddr), .m_al_arvalid(m_al_arvalid), .m_al_arid(m_al_arid),
    .m_al_arready(m_al_arready),
    .m_al_rdata(m_al_rdata), .m_al_rvalid(m_al_rvalid), .m_al_rid(m_al_rid),
    .m_al_rready(m_al_rready), .rd_err(rd_err)
  );

  typedef struct { int port; logic [IW-1:0] id; } rd_t;
  rd_t           rq[$];
  logic [N-1:0]  wv, arv, rrdy;
  logic [AW-1:0] wa[N], aa[N];
  logic [DW-1:0] wd[N];
  logic [IW-1:0] wi[N], ai[N];
  logic          mwr, marr, r_act;
  logic [DW-1:0] r_data;
  logic [IW-1:0] r_id;
  int            w_ptr, ar_ptr, w_li, ar_li;
  bit            w_lk, ar_lk;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      sn_al_waddr[i*AW +: AW]  = wa[i];
      sn_al_wdata[i*DW +: DW]  = wd[i];
      sn_al_wid[i*IW +: IW]    = wi[i];
      sn_al_araddr[i*AW +: AW] = aa[i];
      sn_al_arid[i*IW +: IW]   = ai[i];
    end
    sn_al_wvalid  = wv;
    sn_al_arvalid = arv;
    sn_al_rready  = rrdy;
    m_al_wready   = mwr;
    m_al_arready  = marr;
    m_al_rvalid   = r_act;
    m_al_rdata    = r_data;
    m_al_rid      = MIW'(r_id);
  endtask

  task automatic clear_all();
    wv = '0; arv = '0; rrdy = '0; mwr = 1'b0; marr = 1'b0;
    r_act = 1'b0; r_data = '0; r_id = '0;
    for (int i = 0; i < N; i++) begin
      wa[i] = '0; aa[i] = '0; wd[i] = '0; wi[i] = '0; ai[i] = '0;
    end
    rq.delete();
    w_ptr = 0; ar_ptr = 0; w_lk = 1'b0; ar_lk = 1'b0; w_li = 0; ar_li = 0;
    drive();
  endtask

  task automatic run_cycles(input int n, input int ar_pct, input int r_pct);
    int           wg, ag, head;
    logic [N-1:0] arq;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!wv[i] && $urandom_range(99) < 50) begin
          wv[i] = 1'b1; wa[i] = AW'($urandom); wd[i] = $urandom; wi[i] = IW'($urandom);
        end
        if (!arv[i] && $urandom_range(99) < ar_pct) begin
          arv[i] = 1'b1; aa[i] = AW'($urandom); ai[i] = IW'($urandom);
        end
        rrdy[i] = ($urandom_range(99) < 75);
      end
      mwr  = 1'($urandom_range(1));
      marr = 1'($urandom_range(1));
      if (!r_act && rq.size() > 0 && $urandom_range(99) < r_pct) begin
        r_act = 1'b1; r_id = rq[0].id; r_data = $urandom;
      end
      drive();
      #1;
      wg = w_lk ? w_li : pick(wv, w_ptr);
      check("m_wvalid", m_al_wvalid, wg >= 0);
      check("sn_wready", sn_al_wready, (wg >= 0 && mwr) ? (1 << wg) : 0);
      if (wg >= 0) begin
        check("m_waddr", m_al_waddr, wa[wg]);
        check("m_wdata", m_al_wdata, wd[wg]);
        check("m_wid", m_al_wid, wi[wg]);
      end
      arq = (rq.size() >= RDO) ? '0 : arv;
      ag  = ar_lk ? ar_li : pick(arq, ar_ptr);
      check("m_arvalid", m_al_arvalid, ag >= 0);
      check("sn_arready", sn_al_arready, (ag >= 0 && marr) ? (1 << ag) : 0);
      if (ag >= 0) begin
        check("m_araddr", m_al_araddr, aa[ag]);
        check("m_arid", m_al_arid, ai[ag]);
      end
      if (r_act) begin
        head = rq[0].port;
        check("sn_rvalid", sn_al_rvalid, 1 << head);
        check("m_rready", m_al_rready, rrdy[head]);
        check("sn_rdata", sn_al_rdata[head*DW +: DW], r_data);
        check("sn_rid", sn_al_rid[head*IW +: IW], rq[0].id);
      end else begin
        check("sn_rvalid_idle", sn_al_rvalid, 0);
        check("m_rready_idle", m_al_rready, 0);
      end
      check("rd_err_clean", rd_err, 0);

      if (wg >= 0) begin
        if (mwr) begin
          wv[wg] = 1'b0; w_ptr = (wg + 1) % N; w_lk = 1'b0;
        end else begin
          w_lk = 1'b1; w_li = wg;
        end
      end else w_lk = 1'b0;
      if (r_act && rrdy[rq[0].port]) begin
        void'(rq.pop_front());
        r_act = 1'b0;
      end
      if (ag >= 0) begin
        if (marr) begin
          rq.push_back('{ag, ai[ag]});
          arv[ag] = 1'b0; ar_ptr = (ag + 1) % N; ar_lk = 1'b0;
        end else begin
          ar_lk = 1'b1; ar_li = ag;
        end
      end else ar_lk = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clear_all();
    wv = '1; arv = '1; r_act = 1'b1;
    drive();
    repeat (2) @(negedge clk);
    #1;
    check("rst_m_wvalid", m_al_wvalid, 0);
    check("rst_m_arvalid", m_al_arvalid, 0);
    check("rst_sn_wready", sn_al_wready, 0);
    check("rst_sn_arready", sn_al_arready, 0);
    check("rst_sn_rvalid", sn_al_rvalid, 0);
    check("rst_rd_err", rd_err, 0);
    clear_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Both ports streaming writes with target always ready: strict alternation starting at port 0.
    wv = '1; mwr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive();
      #1;
      check("alt_wready", sn_al_wready, (k % 2) ? 2'b10 : 2'b01);
    end
    wv = '0; mwr = 1'b0; w_ptr = 0;
    drive();

    run_cycles(300, 50, 60);
    run_cycles(30, 80, 0);
    run_cycles(300, 50, 60);
    run_cycles(20, 90, 0);

    // Reset with reads outstanding, then late read data must be dropped and flagged.
    @(negedge clk);
    rst_n = 1'b0;
    clear_all();
    #1;
    check("rst2_m_arvalid", m_al_arvalid, 0);
    check("rst2_rd_err", rd_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_al_rvalid = 1'b1;
    m_al_rid    = '0;
    #1;
    check("err_m_rready", m_al_rready, 1);
    check("err_sn_rvalid", sn_al_rvalid, 0);
    @(negedge clk);
    m_al_rvalid = 1'b0;
    #1;
    check("err_set", rd_err, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("err_sticky", rd_err, 1);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("err_async_clear", rd_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("err_after_rst", rd_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
